rzfpga_io: RTL
==============

RZFPGA_IO -- requirements
Module: rzfpga_io

Interface
REQ-001 The block SHALL expose these parameters, one per line (name, default, meaning):
  NUM_KEYS  4  number of push-button channels, legal range 1..15.
  NUM_LEDS  4  number of LED outputs, legal range 1..16.
  DEBOUNCE_CYCLES  500000  consecutive stable cycles required to accept a key change (10 ms at 50 MHz), minimum 1.
  KBD_ADDR  15'h6000  Hack keyboard register address.
  LED_ADDR  15'h6001  LED register address.
  EVT_ADDR  15'h6002  key-event register address, used only when the event feature is compiled in.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
  clk50  in  1  single system clock; all state changes on its rising edge.
  reset_n  in  1  asynchronous, active-low reset.
  key_n  in  NUM_KEYS  raw board buttons, active-low and asynchronous to clk50.
  data_address_bus  in  15  CPU data address.
  data_out_bus  in  16  CPU write data.
  write_enable  in  1  CPU write strobe, qualified by the current address.
  io_rdata  out  16  read data for the addressed I/O register.
  io_hit  out  1  high when data_address_bus equals any implemented I/O address.
  led  out  NUM_LEDS  LED drive, active-high.

Function
REQ-003 Each key_n bit SHALL pass through a 2-flop synchronizer, then be inverted, giving active-high key_sync.
REQ-004 Each channel SHALL keep a stable bit and a counter of width clog2(DEBOUNCE_CYCLES+1).
  - The counter clears whenever key_sync equals stable.
  - Otherwise the counter increments by one each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1, stable takes key_sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles SHALL never change stable.
REQ-005 Latency from a clean key_n edge to the stable change SHALL be exactly 2+DEBOUNCE_CYCLES cycles.
REQ-006 The keyboard value SHALL be 16 bits: i+1, where i is the lowest index with stable set, or 0 if no stable bit is set. Lowest index wins when several keys are pressed.
REQ-007 io_rdata and io_hit SHALL be combinational from data_address_bus and registered state only, giving zero-cycle read latency as the Hack inM path requires.
  - KBD_ADDR returns the keyboard value.
  - LED_ADDR returns the LED register, zero-extended.
  - Any other address returns io_rdata = 0 and io_hit = 0.
REQ-008 On a cycle with write_enable=1 and data_address_bus=LED_ADDR, the LED register SHALL load data_out_bus[NUM_LEDS-1:0]. led SHALL follow one cycle later.
REQ-009 Writes to KBD_ADDR SHALL be ignored. Writes to unmapped addresses SHALL have no effect.
REQ-010 Parameter values outside their legal ranges SHALL halt elaboration with an error.

Reset
REQ-011 While reset_n=0, all state SHALL clear asynchronously: synchronizers, stable bits, counters, the LED register and the event register. led SHALL be 0 and the keyboard value SHALL be 0.
REQ-012 A key held through the release of reset SHALL appear on stable 2+DEBOUNCE_CYCLES cycles after reset_n rises.
REQ-013 Asserting reset mid-debounce SHALL discard the partial count.

Configuration
REQ-014 Macro RZFPGA_IO_EVENT_EN, when defined, SHALL add an event register of NUM_KEYS bits at EVT_ADDR.
  - A 0->1 transition of stable[i] sets bit i.
  - A write of data_out_bus to EVT_ADDR clears every bit that is 1 in data_out_bus (write-1-to-clear).
  - If a set and a clear hit the same bit in the same cycle, set wins.
  - EVT_ADDR is readable (zero-extended) and asserts io_hit.
REQ-015 When RZFPGA_IO_EVENT_EN is undefined, no event register SHALL exist, and EVT_ADDR SHALL behave as an unmapped address.

Structure
REQ-016 Package rzfpga_pkg SHALL hold the default addresses KBD_ADDR, LED_ADDR and EVT_ADDR, plus the 16-bit word-width constant.
REQ-017 A sub-module rzfpga_debounce SHALL implement one channel (synchronizer plus counter plus stable bit) and be instantiated NUM_KEYS times with a generate loop.

Verification
REQ-018 The bench SHALL run with DEBOUNCE_CYCLES=4 and cover these directed scenarios:
  - Debounce latency: hold key_n[1] low from cycle 10 -> stable[1] rises at cycle 16; read at 15'h6000 returns 16'd2.
  - Glitch rejection: key_n[0] low for 3 cycles then high -> keyboard value stays 0 throughout.
  - Simultaneous keys: key_n[2] and key_n[3] both held low and debounced -> read at KBD_ADDR returns 16'd3; releasing key 2 -> returns 16'd4 after 6 cycles.
  - LED write: write 16'hFFF5 to 15'h6001 -> led = 4'b0101 on the next cycle. Reads return 16'h0005. A write to 15'h6000 changes nothing.
  - Reset mid-operation: pulse reset_n low during a debounce count and with led=4'hF -> led=0 immediately, keyboard value 0; the held key is re-accepted 6 cycles after release of reset.
  - Events (RZFPGA_IO_EVENT_EN only): press then release key 0 -> EVT reads 16'h0001; writing 16'h0001 clears it; a coincident press-edge and clear leaves the bit set.

Source files
------------

// File: rtl/rzfpga_pkg.sv
// rzfpga_pkg: shared word width and default I/O register addresses for rzfpga_io.
package rzfpga_pkg;
  localparam int WORD_W = 16;
  localparam logic [14:0] DEF_KBD_ADDR = 15'h6000;
  localparam logic [14:0] DEF_LED_ADDR = 15'h6001;
  localparam logic [14:0] DEF_EVT_ADDR = 15'h6002;
endpackage

// File: rtl/rzfpga_debounce.sv
// rzfpga_debounce: one key channel -- 2-flop synchronizer, stability counter, debounced stable bit.
module rzfpga_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk50,
  input  logic reset_n,
  input  logic key_n,
  output logic stable,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic stable_q, stable_d;
  logic key_sync, done;
  always_comb begin
    sync_d   = {sync_q[0], key_n};
    key_sync = ~sync_q[1];
    done     = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    cnt_d    = (key_sync == stable_q || done) ? '0 : cnt_q + 1'b1;
    stable_d = (key_sync != stable_q && done) ? key_sync : stable_q;
    press    = done && key_sync && !stable_q;
  end
  // synchronizer clears to the released level so reset never looks like a press
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= 2'b11;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end
  assign stable = stable_q;
endmodule

// File: rtl/rzfpga_io.sv
// rzfpga_io: Hack memory-mapped keyboard/LED block with debounced keys; RZFPGA_IO_EVENT_EN adds a W1C key-event register.
module rzfpga_io
  import rzfpga_pkg::*;
#(
  parameter int          NUM_KEYS        = 4,
  parameter int          NUM_LEDS        = 4,
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter logic [14:0] KBD_ADDR        = DEF_KBD_ADDR,
  parameter logic [14:0] LED_ADDR        = DEF_LED_ADDR,
  parameter logic [14:0] EVT_ADDR        = DEF_EVT_ADDR
) (
  input  logic                clk50,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [14:0]         data_address_bus,
  input  logic [WORD_W-1:0]   data_out_bus,
  input  logic                write_enable,
  output logic [WORD_W-1:0]   io_rdata,
  output logic                io_hit,
  output logic [NUM_LEDS-1:0] led
);
  if (NUM_KEYS < 1 || NUM_KEYS > 15) begin : g_bad_keys
    $error("rzfpga_io: NUM_KEYS must be 1..15");
  end
  if (NUM_LEDS < 1 || NUM_LEDS > 16) begin : g_bad_leds
    $error("rzfpga_io: NUM_LEDS must be 1..16");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("rzfpga_io: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [NUM_KEYS-1:0] stable, press;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic [WORD_W-1:0]   kbd, evt_val;
  logic                evt_hit, unused_in;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    rzfpga_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk50  (clk50),
      .reset_n(reset_n),
      .key_n  (key_n[k]),
      .stable (stable[k]),
      .press  (press[k])
    );
  end

  // scanning downward leaves the lowest pressed index in kbd
  always_comb begin
    kbd = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) kbd = stable[i] ? WORD_W'(i + 1) : kbd;
  end

  always_comb led_d = (write_enable && data_address_bus == LED_ADDR) ? data_out_bus[NUM_LEDS-1:0] : led_q;

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) led_q <= '0;
    else led_q <= led_d;
  end

`ifdef RZFPGA_IO_EVENT_EN
  logic [NUM_KEYS-1:0] evt_q, evt_d;
  // press is ORed in last so a coincident set beats the clear
  always_comb begin
    evt_hit = data_address_bus == EVT_ADDR;
    evt_val = evt_hit ? WORD_W'(evt_q) : '0;
    evt_d   = (evt_q & ~({NUM_KEYS{write_enable && evt_hit}} & data_out_bus[NUM_KEYS-1:0])) | press;
  end
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) evt_q <= '0;
    else evt_q <= evt_d;
  end
`else
  assign evt_hit = 1'b0;
  assign evt_val = '0;
`endif

  assign unused_in = ^{press, data_out_bus};
  assign led       = led_q;

  always_comb begin
    io_hit   = data_address_bus == KBD_ADDR || data_address_bus == LED_ADDR || evt_hit;
    io_rdata = data_address_bus == KBD_ADDR ? kbd :
               data_address_bus == LED_ADDR ? WORD_W'(led_q) : evt_val;
  end
endmodule
